// File: rtl/change_return_ctrl_pkg.sv
// Shared constants for change return: balance width, coin values, select codes, FSM states.
package change_return_ctrl_pkg;

    localparam int kTotalBits = 16;
    localparam int kCoin100   = 100;
    localparam int kCoin500   = 500;
    localparam int kCoin1000  = 1000;

    typedef enum logic [1:0] {
        COIN_100  = 2'd0,
        COIN_500  = 2'd1,
        COIN_1000 = 2'd2
    } coin_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EJECT  = 2'd2,
        ST_DONE   = 2'd3
    } cr_state_e;

    function automatic int unsigned coin_value(logic [1:0] sel);
        case (sel)
            COIN_1000: return kCoin1000;
            COIN_500:  return kCoin500;
            default:   return kCoin100;
        endcase
    endfunction

endpackage

// File: rtl/change_return_ctrl_coin_greedy_sel.sv
// Largest-coin-first picker: chooses the biggest coin not exceeding the remaining balance.
module coin_greedy_sel
    import change_return_ctrl_pkg::*;
#(
    parameter int W = kTotalBits
) (
    input  logic [W-1:0] remaining,
    output logic [1:0]   sel,
    output logic [W-1:0] value,
    output logic         has_coin
);

    always_comb begin
        sel      = COIN_100;
        has_coin = 1'b1;
        if (remaining >= W'(kCoin1000)) begin
            sel = COIN_1000;
        end else if (remaining >= W'(kCoin500)) begin
            sel = COIN_500;
        end else if (remaining < W'(kCoin100)) begin
            has_coin = 1'b0;
        end
        value = W'(coin_value(sel));
    end

endmodule

// File: rtl/change_return_ctrl.sv
// Change return sequencer: greedy coin ejection with write-back of each decremented balance.
// Optional idle-timeout auto return is compiled in with VM_TIMEOUT_RETURN_EN.
module change_return_ctrl
    import change_return_ctrl_pkg::*;
#(
    parameter int TOTAL_BITS     = kTotalBits,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TOTAL_BITS-1:0] i_total,
    input  logic                  i_return_req,
    input  logic                  i_activity,
    input  logic                  i_coin_ready,
    output logic                  o_coin_valid,
    output logic [1:0]            o_coin_sel,
    output logic                  o_total_load,
    output logic [TOTAL_BITS-1:0] o_total_nxt,
    output logic                  o_busy,
    output logic                  o_done
);

    cr_state_e             state_q, state_d;
    logic [TOTAL_BITS-1:0] rem_q, rem_d;
    logic [TOTAL_BITS-1:0] val_q, val_d;
    logic [1:0]            sel_q, sel_d;
    logic                  load_q, load_d;
    logic [TOTAL_BITS-1:0] nxt_q, nxt_d;

    logic [1:0]            g_sel;
    logic [TOTAL_BITS-1:0] g_value;
    logic                  g_has_coin;
    logic                  tmo_fire;
    logic                  trigger;

    coin_greedy_sel #(.W(TOTAL_BITS)) u_greedy (
        .remaining (rem_q),
        .sel       (g_sel),
        .value     (g_value),
        .has_coin  (g_has_coin)
    );

`ifdef VM_TIMEOUT_RETURN_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_q, tmo_d;

    // Counts idle cycles with a nonzero balance; any activity restarts the wait.
    always_comb begin
        tmo_fire = (state_q == ST_IDLE) && (tmo_q == CW'(TIMEOUT_CYCLES - 1));
        tmo_d    = tmo_q + 1'b1;
        if (state_q != ST_IDLE || tmo_fire || i_activity || i_total == '0) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_activity;
    assign unused_activity = i_activity;
    assign tmo_fire        = 1'b0;
`endif

    assign trigger = i_return_req || tmo_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            val_q   <= '0;
            sel_q   <= '0;
            load_q  <= 1'b0;
            nxt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            sel_q   <= sel_d;
            load_q  <= load_d;
            nxt_q   <= nxt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        val_d   = val_q;
        sel_d   = sel_q;
        load_d  = 1'b0;
        nxt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    rem_d   = i_total;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (g_has_coin) begin
                    sel_d   = g_sel;
                    val_d   = g_value;
                    state_d = ST_EJECT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_EJECT: begin
                // val_q never exceeds rem_q, so this cannot underflow.
                if (i_coin_ready) begin
                    rem_d   = rem_q - val_q;
                    load_d  = 1'b1;
                    nxt_d   = rem_q - val_q;
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_coin_valid = 1'b0;
        o_coin_sel   = '0;
        o_done       = 1'b0;
        o_busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_EJECT: begin
                o_coin_valid = 1'b1;
                o_coin_sel   = sel_q;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
        o_total_load = load_q;
        o_total_nxt  = nxt_q;
    end

endmodule

// File: tb/tb_change_return_ctrl.sv
// Scoreboard bench for change_return_ctrl: greedy reference model feeds queues, negedge monitor checks.
module tb_change_return_ctrl;
    import change_return_ctrl_pkg::*;

    localparam int TB  = kTotalBits;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [TB-1:0] i_total;
    logic          i_return_req, i_activity, i_coin_ready;
    logic          o_coin_valid, o_total_load, o_busy, o_done;
    logic [1:0]    o_coin_sel;
    logic [TB-1:0] o_total_nxt;

    change_return_ctrl #(.TOTAL_BITS(TB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_total      (i_total),
        .i_return_req (i_return_req),
        .i_activity   (i_activity),
        .i_coin_ready (i_coin_ready),
        .o_coin_valid (o_coin_valid),
        .o_coin_sel   (o_coin_sel),
        .o_total_load (o_total_load),
        .o_total_nxt  (o_total_nxt),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected DUT events, filled by the stimulus side from the reference model.
    int     exp_coin[$];
    int     exp_load[$];
    int     exp_done[$];
    // Directed checks handed to the monitor so that it alone owns the tallies.
    string  chk_name[$];
    longint chk_act[$];
    longint chk_exp[$];

    int n_cmp = 0, n_fail = 0;
    int done_cnt = 0, last_done_cyc = 0, hs_cnt = 0, load_cnt = 0, v500_cnt = 0;
    bit rand_rdy = 1'b0;

    always @(negedge clk) begin
        int     c, f, e;
        string  nm;
        longint a, x;
        c = 0; f = 0;
        if (!reset) begin
            if (o_coin_valid && i_coin_ready) begin
                c++;
                if (exp_coin.size() == 0) begin
                    f++; $display("FAIL coin_sel: got unexpected coin %0d, expected none", o_coin_sel);
                end else begin
                    e = exp_coin.pop_front();
                    if (int'(o_coin_sel) != e) begin
                        f++; $display("FAIL coin_sel: got %0d, expected %0d", o_coin_sel, e);
                    end
                end
            end
            if (o_total_load) begin
                c++;
                if (exp_load.size() == 0) begin
                    f++; $display("FAIL total_load: got unexpected load %0d, expected none", o_total_nxt);
                end else begin
                    e = exp_load.pop_front();
                    if (int'(o_total_nxt) != e) begin
                        f++; $display("FAIL total_nxt: got %0d, expected %0d", o_total_nxt, e);
                    end
                end
            end else begin
                c++;
                if (o_total_nxt != '0) begin
                    f++; $display("FAIL nxt_idle_zero: got %0d, expected 0", o_total_nxt);
                end
            end
            if (o_done) begin
                c++;
                if (exp_done.size() == 0) begin
                    f++; $display("FAIL done: got unexpected done pulse, expected none");
                end else begin
                    void'(exp_done.pop_front());
                end
            end
            if (o_coin_valid && o_coin_sel == 2'd1) v500_cnt <= v500_cnt + 1;
            if (o_coin_valid && i_coin_ready)       hs_cnt <= hs_cnt + 1;
            if (o_total_load)                       load_cnt <= load_cnt + 1;
            if (o_done) begin
                done_cnt      <= done_cnt + 1;
                last_done_cyc <= cyc;
            end
        end
        while (chk_name.size() > 0) begin
            nm = chk_name.pop_front();
            a  = chk_act.pop_front();
            x  = chk_exp.pop_front();
            c++;
            if (a != x) begin
                f++; $display("FAIL %s: got %0d, expected %0d", nm, a, x);
            end
        end
        n_cmp  <= n_cmp + c;
        n_fail <= n_fail + f;
    end

    task automatic push_chk(input string n, input longint a, input longint x);
        chk_name.push_back(n);
        chk_act.push_back(a);
        chk_exp.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) i_coin_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference model: repeatedly hand out the largest coin that fits; residue below 100 stays.
    task automatic expect_return(input int total);
        int r;
        r = total;
        while (r >= 100) begin
            if (r >= 1000)     begin exp_coin.push_back(2); r -= 1000; end
            else if (r >= 500) begin exp_coin.push_back(1); r -= 500;  end
            else               begin exp_coin.push_back(0); r -= 100;  end
            exp_load.push_back(r);
        end
        exp_done.push_back(1);
    endtask

    task automatic request(output int t);
        i_return_req = 1'b1;
        tick();
        t = cyc;
        i_return_req = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, input string n);
        int k;
        k = 0;
        while (done_cnt == prev && k < budget) begin
            tick();
            k++;
        end
        push_chk(n, longint'(done_cnt != prev), 1);
    endtask

    task automatic wait_busy(input int budget, output int e);
        int k;
        k = 0;
        e = -1;
        while (!o_busy && k < budget) begin
            tick();
            k++;
        end
        if (o_busy) e = cyc;
    endtask

    task automatic check_outputs_zero(input string n);
        push_chk({n, "_valid"}, o_coin_valid, 0);
        push_chk({n, "_sel"},   o_coin_sel,   0);
        push_chk({n, "_load"},  o_total_load, 0);
        push_chk({n, "_nxt"},   o_total_nxt,  0);
        push_chk({n, "_busy"},  o_busy,       0);
        push_chk({n, "_done"},  o_done,       0);
    endtask

    initial begin
        int t, p, h0, l0, v0, s, be, ae, tot;
        reset = 1'b1; i_total = '0; i_return_req = 1'b0; i_activity = 1'b0; i_coin_ready = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Greedy order with ready held high.
        i_total = TB'(1600); i_coin_ready = 1'b1;
        expect_return(1600);
        p = done_cnt; h0 = hs_cnt;
        request(t);
        push_chk("busy_in_select", o_busy, 1);
        wait_done(p, 40, "greedy_done_seen");
        push_chk("greedy_latency", last_done_cyc - t + 1, 8);
        push_chk("greedy_coins", hs_cnt - h0, 3);
        i_total = '0; tick();

        // Backpressure: ready low for the first 5 EJECT cycles.
        i_total = TB'(500); i_coin_ready = 1'b0;
        expect_return(500);
        p = done_cnt; v0 = v500_cnt; l0 = load_cnt;
        request(t);
        tick();
        repeat (5) tick();
        i_coin_ready = 1'b1;
        wait_done(p, 40, "bp_done_seen");
        push_chk("bp_valid_cycles", v500_cnt - v0, 6);
        push_chk("bp_loads", load_cnt - l0, 1);
        i_total = '0; tick();

        // Residue below the smallest coin stays in the balance.
        i_total = TB'(150);
        expect_return(150);
        p = done_cnt; h0 = hs_cnt;
        request(t);
        wait_done(p, 40, "residue_done_seen");
        push_chk("residue_coins", hs_cnt - h0, 1);
        i_total = '0; tick();

        // Zero balance: done two cycles after the request edge, nothing dispensed.
        expect_return(0);
        p = done_cnt; h0 = hs_cnt; l0 = load_cnt;
        request(t);
        wait_done(p, 40, "zero_done_seen");
        push_chk("zero_latency", last_done_cyc - t + 1, 2);
        push_chk("zero_coins", hs_cnt - h0, 0);
        push_chk("zero_loads", load_cnt - l0, 0);
        tick();

        // Reset while a coin is offered but not yet accepted.
        i_total = TB'(1000); i_coin_ready = 1'b0;
        l0 = load_cnt; h0 = hs_cnt;
        request(t);
        tick();
        push_chk("mid_valid_before_reset", o_coin_valid, 1);
        reset = 1'b1;
        tick();
        check_outputs_zero("mid_reset");
        i_total = '0; reset = 1'b0; i_coin_ready = 1'b1;
        repeat (4) tick();
        push_chk("mid_reset_no_load", load_cnt - l0, 0);
        push_chk("mid_reset_no_coin", hs_cnt - h0, 0);

        // Randomized balances with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tot = $urandom_range(0, 40) * 100;
            if ($urandom_range(0, 3) == 0) tot += $urandom_range(1, 99);
            i_total = TB'(tot);
            expect_return(tot);
            p = done_cnt;
            request(t);
            wait_done(p, 300, "rand_done_seen");
            push_chk("rand_drain", exp_coin.size() + exp_load.size() + exp_done.size(), 0);
            i_total = '0;
            tick();
        end
        rand_rdy = 1'b0; i_coin_ready = 1'b1;
        tick();

`ifdef VM_TIMEOUT_RETURN_EN
        // Idle timeout fires TMO edges after counting starts.
        i_total = '0; tick();
        i_total = TB'(1000); s = cyc;
        expect_return(1000);
        p = done_cnt;
        wait_busy(4 * TMO, be);
        push_chk("timeout_edge", be - s, TMO);
        wait_done(p, 40, "timeout_done_seen");
        i_total = '0; tick();

        // An activity pulse restarts the idle count.
        i_total = TB'(1000); s = cyc;
        expect_return(1000);
        p = done_cnt;
        repeat (7) tick();
        i_activity = 1'b1;
        tick();
        ae = cyc;
        i_activity = 1'b0;
        wait_busy(4 * TMO, be);
        push_chk("activity_timeout_edge", be, ae + TMO);
        push_chk("activity_delay", be - (s + TMO), ae - s);
        wait_done(p, 40, "activity_done_seen");
        i_total = '0; tick();
`else
        // Without the timeout a held balance is never returned on its own.
        i_total = TB'(1000); s = cyc;
        wait_busy(3 * TMO, be);
        push_chk("no_timeout_return", be, -1);
        i_total = '0; tick();
`endif

        push_chk("final_drain", exp_coin.size() + exp_load.size() + exp_done.size(), 0);
        repeat (2) tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
